// File: rtl/prog_loader_if.sv
// Command port between a host and the serial program loader.
interface prog_loader_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_addr,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_addr,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/prog_loader.sv
// Host-side serial master for the tiny processor core: serialises WRITE
// commands into 12-bit instruction-cache frames and runs the core for a
// programmed number of cycles on RUN commands.
module prog_loader #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    prog_loader_if.slave cmd,
    input  logic         run_stop,
    output logic         csi_n,
    output logic         csd_n,
    output logic         mosi,
    output logic         proc_en,
    output logic         busy,
    output logic         done
);

    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SHIFT,
        S_HOLD,
        S_RUN,
        S_COOL
    } state_t;

    state_t        state_q, state_d;
    logic [11:0]   frame_q, frame_d;
    logic [3:0]    bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    run_q, run_d;
    logic          csi_n_q, csi_n_d;
    logic          mosi_q, mosi_d;
    logic          proc_en_q, proc_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Ready is decoded from the state register alone.
    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign csd_n         = 1'b1;
    assign csi_n         = csi_n_q;
    assign mosi          = mosi_q;
    assign proc_en       = proc_en_q;
    assign busy          = busy_q;
    assign done          = done_q;

    // State, counters and registered pin values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            bit_q     <= '0;
            gap_q     <= '0;
            run_q     <= '0;
            csi_n_q   <= 1'b1;
            mosi_q    <= 1'b0;
            proc_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_q     <= bit_d;
            gap_q     <= gap_d;
            run_q     <= run_d;
            csi_n_q   <= csi_n_d;
            mosi_q    <= mosi_d;
            proc_en_q <= proc_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state and counters; pin values are derived from the next state so
    // every output comes straight from a flop.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        run_d   = run_q;

        case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid) begin
                    frame_d = {cmd.cmd_data, cmd.cmd_addr};
                    if (cmd.cmd_op) begin
                        run_d   = cmd.cmd_data;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_PRE;
                    end
                end
            end
            S_PRE: begin
                bit_d   = 4'd0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // Bit 11 is presented in the first HOLD cycle, after csi_n rises.
                bit_d = bit_q + 4'd1;
                if (bit_q == 4'd10) begin
                    gap_d   = GAP_LAST;
                    state_d = S_HOLD;
                end
            end
            S_RUN: begin
                if (run_stop || (run_q == 8'd0)) begin
                    gap_d   = GAP_LAST;
                    state_d = S_COOL;
                end else begin
                    run_d = run_q - 8'd1;
                end
            end
            S_HOLD, S_COOL: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        csi_n_d   = !((state_d == S_PRE) || (state_d == S_SHIFT));
        mosi_d    = ((state_d == S_SHIFT) ||
                     ((state_d == S_HOLD) && (gap_d == GAP_LAST))) ? frame_d[bit_d] : 1'b0;
        proc_en_d = (state_d == S_RUN);
        busy_d    = (state_d != S_IDLE);
        done_d    = ((state_d == S_HOLD) || (state_d == S_COOL)) && (gap_d == '0);
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed, table-driven bench for prog_loader with a small core-side
// frame receiver model.
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst_n;
    logic run_stop;
    logic csi_n, csd_n, mosi, proc_en, busy, done;

    prog_loader_if bus ();

    prog_loader #(.GAP_CYCLES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (bus),
        .run_stop (run_stop),
        .csi_n    (csi_n),
        .csd_n    (csd_n),
        .mosi     (mosi),
        .proc_en  (proc_en),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Core receive model: a bit is taken in each cycle following a csi_n-low cycle.
    logic [7:0]  icache [16];
    logic [11:0] sr;
    int          nbits;
    logic        prev_low;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nbits    = 0;
            prev_low = 1'b0;
        end else begin
            if (prev_low && nbits < 12) begin
                sr[nbits] = mosi;
                nbits++;
            end
            if (csi_n && !prev_low) nbits = 0;
            if (nbits == 12) begin
                icache[sr[3:0]] = sr[11:4];
                nbits = 0;
            end
            prev_low = !csi_n;
        end
    end

    // Sticky protocol violations, reported once at the end.
    logic excl_bad = 1'b0;
    logic csd_bad  = 1'b0;
    always @(negedge clk) begin
        if (proc_en === 1'b1 && csi_n === 1'b0) excl_bad = 1'b1;
        if (csd_n !== 1'b1) csd_bad = 1'b1;
    end

    typedef struct {
        logic        op;
        logic [3:0]  addr;
        logic [7:0]  data;
        int          stop_at;
        logic [11:0] exp_frame;
        int          exp_low;
        int          exp_en;
        int          exp_done;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 100) begin
            step();
            w++;
        end
        if (w >= 100) chk({name, "_ready_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic do_cmd(input vec_t v, output logic [11:0] fr, output int low,
                          output int en, output int didx, output logic mx);
        fr   = '0;
        low  = 0;
        en   = 0;
        didx = -1;
        mx   = 1'b0;
        wait_ready("cmd");
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.cmd_addr  = v.addr;
        bus.cmd_data  = v.data;
        step();
        bus.cmd_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!csi_n) low++;
            if (proc_en) en++;
            if (c >= 1 && c <= 12) fr[c-1] = mosi;
            if (c == 0 || c >= 13 || v.op) mx = mx | mosi;
            if (done) begin
                didx = c;
                break;
            end
            run_stop = (c == v.stop_at);
            step();
        end
        run_stop = 1'b0;
    endtask

    vec_t        vecs [10];
    logic [11:0] fr;
    int          low, en, didx;
    logic        mx;

    initial begin
        vecs[0] = '{1'b0, 4'h3, 8'hA5, -1, 12'hA53, 12, 0, 13};
        vecs[1] = '{1'b0, 4'h0, 8'h00, -1, 12'h000, 12, 0, 13};
        vecs[2] = '{1'b0, 4'hF, 8'hFF, -1, 12'hFFF, 12, 0, 13};
        vecs[3] = '{1'b0, 4'h9, 8'h3C,  4, 12'h3C9, 12, 0, 13};
        vecs[4] = '{1'b0, 4'h6, 8'h81, -1, 12'h816, 12, 0, 13};
        vecs[5] = '{1'b1, 4'h0, 8'h09, -1, 12'h000, 0, 10, 11};
        vecs[6] = '{1'b1, 4'h7, 8'h00, -1, 12'h000, 0, 1, 2};
        vecs[7] = '{1'b1, 4'h5, 8'hFF, -1, 12'h000, 0, 256, 257};
        vecs[8] = '{1'b1, 4'h0, 8'hFF,  5, 12'h000, 0, 6, 7};
        vecs[9] = '{1'b1, 4'h0, 8'h01,  0, 12'h000, 0, 1, 2};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        run_stop      = 1'b0;
        rst_n         = 1'b1;
        #2 rst_n = 1'b0;
        step();
        step();
        chk("rst_csi_n", csi_n, 1);
        chk("rst_mosi", mosi, 0);
        chk("rst_proc_en", proc_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", bus.cmd_ready, 1);
        chk("post_rst_csi_n", csi_n, 1);

        // Table of single commands.
        for (int i = 0; i < 10; i++) begin
            do_cmd(vecs[i], fr, low, en, didx, mx);
            chk($sformatf("v%0d_done_cycle", i), didx, vecs[i].exp_done);
            chk($sformatf("v%0d_csi_low", i), low, vecs[i].exp_low);
            chk($sformatf("v%0d_proc_en", i), en, vecs[i].exp_en);
            chk($sformatf("v%0d_mosi_idle", i), mx, 0);
            if (!vecs[i].op) begin
                chk($sformatf("v%0d_frame", i), fr, vecs[i].exp_frame);
                chk($sformatf("v%0d_icache", i), icache[vecs[i].addr], vecs[i].data);
            end
            step();
            chk($sformatf("v%0d_ready_after", i), bus.cmd_ready, 1);
            chk($sformatf("v%0d_busy_after", i), busy, 0);
            chk($sformatf("v%0d_done_pulse", i), done, 0);
        end

        // Back-to-back WRITEs with cmd_valid held high.
        begin
            int acc, last, c;
            logic [3:0] a;
            acc  = 0;
            last = 0;
            c    = 0;
            a    = 4'd0;
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 1'b0;
            bus.cmd_addr  = a;
            bus.cmd_data  = {a, ~a};
            while (acc < 16 && c < 400) begin
                if (bus.cmd_ready) begin
                    if (acc > 0) chk($sformatf("b2b_gap%0d", acc), c - last, 15);
                    last = c;
                    acc++;
                    step();
                    a = 4'(acc);
                    bus.cmd_addr = a;
                    bus.cmd_data = {a, ~a};
                    if (acc == 16) bus.cmd_valid = 1'b0;
                end else begin
                    step();
                end
                c++;
            end
            bus.cmd_valid = 1'b0;
            chk("b2b_accepted", acc, 16);
            wait_ready("b2b");
            for (int k = 0; k < 16; k++) begin
                a = 4'(k);
                chk($sformatf("b2b_icache%0d", k), icache[k], {a, ~a});
            end
        end

        // Command offered while busy waits for the first IDLE cycle.
        begin
            int early_rdy, early_en, run_len, w;
            early_rdy = 0;
            early_en  = 0;
            wait_ready("busyq");
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 1'b0;
            bus.cmd_addr  = 4'h7;
            bus.cmd_data  = 8'h5A;
            step();
            bus.cmd_valid = 1'b0;
            step();
            step();
            step();
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 1'b1;
            bus.cmd_addr  = 4'h0;
            bus.cmd_data  = 8'h02;
            for (int c = 3; c <= 14; c++) begin
                if (c < 14 && bus.cmd_ready) early_rdy++;
                if (proc_en) early_en++;
                if (c == 13) chk("busyq_done", done, 1);
                if (c == 14) chk("busyq_ready_idle", bus.cmd_ready, 1);
                step();
            end
            bus.cmd_valid = 1'b0;
            chk("busyq_early_ready", early_rdy, 0);
            chk("busyq_early_en", early_en, 0);
            chk("busyq_run_start", proc_en, 1);
            chk("busyq_icache", icache[7], 8'h5A);
            run_len = 0;
            w = 0;
            while (proc_en && w < 50) begin
                run_len++;
                step();
                w++;
            end
            chk("busyq_run_len", run_len, 3);
            wait_ready("busyq_end");
        end

        // Asynchronous reset in the middle of a frame.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b0;
        bus.cmd_addr  = 4'h2;
        bus.cmd_data  = 8'hC3;
        step();
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("mid_shift_csi_low", csi_n, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_shift_csi_n", csi_n, 1);
        chk("arst_shift_proc_en", proc_en, 0);
        chk("arst_shift_ready", bus.cmd_ready, 1);
        chk("arst_shift_busy", busy, 0);
        chk("arst_shift_mosi", mosi, 0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("arst_shift_icache", icache[2], {4'h2, ~4'h2});

        // Asynchronous reset in the middle of a run.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b1;
        bus.cmd_data  = 8'hFF;
        step();
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("mid_run_proc_en", proc_en, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_run_proc_en", proc_en, 0);
        chk("arst_run_ready", bus.cmd_ready, 1);
        step();
        rst_n = 1'b1;
        step();

        chk("exclusivity", excl_bad, 0);
        chk("csd_n_high", csd_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
